// File: rtl/cpu_defs_pkg.sv
// Shared CPU datapath definitions used by the MEM/WB, ID and EX stages.
package cpu_defs;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_mux.sv
// Write-back source select: load data or ALU result. Also reused by the EX forwarding path.
module wb_mux
    import cpu_defs::*;
#(
    parameter int W = cpu_defs::DATA_W
) (
    input  logic         mem_to_reg_i,
    input  logic [W-1:0] read_data_i,
    input  logic [W-1:0] write_data_i,
    output logic [W-1:0] wb_data_o
);

    assign wb_data_o = mem_to_reg_i ? read_data_i : write_data_i;

endmodule

// File: rtl/wb_register_file.sv
// Write-back stage and architectural register file with write-through read bypass
// and a retired-write counter.
module wb_register_file
    import cpu_defs::*;
#(
    parameter int DATA_W   = cpu_defs::DATA_W,
    parameter int ADDR_W   = cpu_defs::ADDR_W,
    parameter int NUM_REGS = cpu_defs::NUM_REGS,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] write_reg_addr,
    input  logic [ADDR_W-1:0] read_reg1_addr,
    input  logic [ADDR_W-1:0] read_reg2_addr,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_commit,
    output logic [CNT_W-1:0]  wb_count
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    wb_mux #(
        .W (DATA_W)
    ) u_wb_mux (
        .mem_to_reg_i (mem_to_reg),
        .read_data_i  (read_data),
        .write_data_i (write_data),
        .wb_data_o    (wb_data)
    );

    // Reset gates commit so a write presented while reset is high is dropped and never bypassed.
    assign wb_commit = reg_write && (write_reg_addr != ZERO_ADDR) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_commit) begin
            regs_q[write_reg_addr] <= wb_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (wb_commit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wb_count = cnt_q;

    // Bypass gives "write first half, read second half" so ID never needs WB forwarding.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (reset || addr == ZERO_ADDR) begin
            val = '0;
        end else if (wb_commit && addr == write_reg_addr) begin
            val = wb_data;
        end else begin
            val = regs_q[addr];
        end
        return val;
    endfunction

    always_comb begin
        read_data1 = read_port(read_reg1_addr);
        read_data2 = read_port(read_reg2_addr);
    end

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: vector table with scoreboard queue plus
// hand sequences for reset, async reset mid-run and counter wrap.
module tb_wb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] write_data;
    logic [4:0]  write_reg_addr;
    logic [4:0]  read_reg1_addr;
    logic [4:0]  read_reg2_addr;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] wb_data;
    logic        wb_commit;
    logic [31:0] wb_count;

    logic [31:0] read_data1_w;
    logic [31:0] read_data2_w;
    logic [31:0] wb_data_w;
    logic        wb_commit_w;
    logic [3:0]  wb_count_w;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    wb_register_file dut (
        .clk            (clk),
        .reset          (reset),
        .reg_write      (reg_write),
        .mem_to_reg     (mem_to_reg),
        .read_data      (read_data),
        .write_data     (write_data),
        .write_reg_addr (write_reg_addr),
        .read_reg1_addr (read_reg1_addr),
        .read_reg2_addr (read_reg2_addr),
        .read_data1     (read_data1),
        .read_data2     (read_data2),
        .wb_data        (wb_data),
        .wb_commit      (wb_commit),
        .wb_count       (wb_count)
    );

    // Narrow-counter instance sharing all inputs, used to reach the wrap point quickly.
    wb_register_file #(.CNT_W(4)) dut_w (
        .clk            (clk),
        .reset          (reset),
        .reg_write      (reg_write),
        .mem_to_reg     (mem_to_reg),
        .read_data      (read_data),
        .write_data     (write_data),
        .write_reg_addr (write_reg_addr),
        .read_reg1_addr (read_reg1_addr),
        .read_reg2_addr (read_reg2_addr),
        .read_data1     (read_data1_w),
        .read_data2     (read_data2_w),
        .wb_data        (wb_data_w),
        .wb_commit      (wb_commit_w),
        .wb_count       (wb_count_w)
    );

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] wd;
        logic [4:0]  wa;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_wb;
        logic        e_commit;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [10];
    vec_t sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic [31:0] rd,
                         input logic [31:0] wd, input logic [4:0] wa,
                         input logic [4:0] r1, input logic [4:0] r2);
        reg_write      = rw;
        mem_to_reg     = m2r;
        read_data      = rd;
        write_data     = wd;
        write_reg_addr = wa;
        read_reg1_addr = r1;
        read_reg2_addr = r2;
    endtask

    function automatic vec_t mk(logic rw, logic m2r, logic [31:0] rd, logic [31:0] wd,
                                logic [4:0] wa, logic [4:0] r1, logic [4:0] r2,
                                logic [31:0] e1, logic [31:0] e2, logic [31:0] ewb,
                                logic ec, logic [31:0] ecnt);
        vec_t v;
        v.rw = rw; v.m2r = m2r; v.rd = rd; v.wd = wd; v.wa = wa; v.r1 = r1; v.r2 = r2;
        v.e_rd1 = e1; v.e_rd2 = e2; v.e_wb = ewb; v.e_commit = ec; v.e_cnt = ecnt;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;

        vecs[0] = mk(1, 0, 32'h0, 32'hDEADBEEF, 5, 5, 0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1, 1);
        vecs[1] = mk(0, 0, 32'h0, 32'h0, 5, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 0, 1);
        vecs[2] = mk(1, 1, 32'h12345678, 32'hAAAA0000, 9, 9, 9, 32'h12345678, 32'h12345678, 32'h12345678, 1, 2);
        vecs[3] = mk(1, 0, 32'h0, 32'hFFFFFFFF, 0, 0, 9, 32'h0, 32'h12345678, 32'hFFFFFFFF, 0, 2);
        vecs[4] = mk(0, 0, 32'h0, 32'h0, 0, 0, 5, 32'h0, 32'hDEADBEEF, 32'h0, 0, 2);
        vecs[5] = mk(1, 0, 32'h0, 32'h11112222, 5, 5, 9, 32'h11112222, 32'h12345678, 32'h11112222, 1, 3);
        vecs[6] = mk(0, 1, 32'hCAFEF00D, 32'h0, 5, 5, 31, 32'h11112222, 32'h0, 32'hCAFEF00D, 0, 3);
        vecs[7] = mk(1, 1, 32'hCAFEF00D, 32'h0, 31, 30, 31, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 1, 4);
        vecs[8] = mk(0, 0, 32'h0, 32'h0, 31, 31, 9, 32'hCAFEF00D, 32'h12345678, 32'h0, 0, 4);
        vecs[9] = mk(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 4);

        // Reset held for two edges; a write presented meanwhile must be discarded.
        reset = 1'b1;
        drive(1, 0, 32'h0, 32'h55AA55AA, 3, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_commit", {31'b0, wb_commit}, 32'h0);
        chk("reset_wb_data", wb_data, 32'h55AA55AA);
        chk("reset_count", wb_count, 32'h0);
        for (int i = 0; i < 32; i++) begin
            read_reg1_addr = 5'(i);
            read_reg2_addr = 5'(31 - i);
            #0.1;
            chk($sformatf("reset_rd1_%0d", i), read_data1, 32'h0);
            chk($sformatf("reset_rd2_%0d", i), read_data2, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 32'h0, 32'h0, 0, 3, 3);
        #2;
        chk("reset_write_lost", read_data1, 32'h0);

        // Table: expectations queued at drive time, popped when outputs are sampled.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(vecs[k].rw, vecs[k].m2r, vecs[k].rd, vecs[k].wd,
                  vecs[k].wa, vecs[k].r1, vecs[k].r2);
            sb_q.push_back(vecs[k]);
            #2;
            v = sb_q.pop_front();
            chk($sformatf("v%0d_rd1", k), read_data1, v.e_rd1);
            chk($sformatf("v%0d_rd2", k), read_data2, v.e_rd2);
            chk($sformatf("v%0d_wb", k), wb_data, v.e_wb);
            chk($sformatf("v%0d_commit", k), {31'b0, wb_commit}, {31'b0, v.e_commit});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_count", k), wb_count, v.e_cnt);
        end

        // Unknown data and address with reg_write low leave state alone.
        @(negedge clk);
        drive(0, 'x, 'x, 'x, 'x, 5, 31);
        #2;
        chk("x_commit", {31'b0, wb_commit}, 32'h0);
        @(posedge clk);
        #1;
        chk("x_count", wb_count, 32'd4);
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 0, 5, 31);
        #2;
        chk("x_rd1", read_data1, 32'h11112222);
        chk("x_rd2", read_data2, 32'hCAFEF00D);

        // Async reset mid-run.
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            drive(1, 0, 32'h0, 32'd100 + 32'(i), 5'(i), 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 0, 1, 4);
        #2;
        chk("pre_rst_rd1", read_data1, 32'd101);
        chk("pre_rst_rd2", read_data2, 32'd104);
        chk("pre_rst_count", wb_count, 32'd8);
        reset = 1'b1;
        #1;
        chk("async_rd1", read_data1, 32'h0);
        chk("async_rd2", read_data2, 32'h0);
        chk("async_count", wb_count, 32'h0);
        drive(1, 0, 32'h0, 32'd77, 7, 7, 4);
        #0.1;
        chk("async_commit", {31'b0, wb_commit}, 32'h0);
        chk("async_bypass_off", read_data1, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 32'h0, 32'h0, 0, 7, 4);
        #2;
        chk("post_rst_rd7", read_data1, 32'h0);
        chk("post_rst_rd4", read_data2, 32'h0);
        chk("post_rst_count", wb_count, 32'h0);
        @(negedge clk);
        drive(1, 0, 32'h0, 32'h55, 2, 0, 0);
        @(posedge clk);
        #1;
        chk("first_edge_count", wb_count, 32'd1);
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 0, 2, 0);
        #2;
        chk("first_edge_rd2", read_data1, 32'h55);

        // Counter wrap on the 4-bit instance: 15 commits reach all-ones, the 16th wraps.
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            drive(1, 0, 32'h0, 32'h1000 + 32'(k), 5'(10 + k), 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 0, 10, 23);
        #2;
        chk("wrap_pre_count_w", {28'b0, wb_count_w}, 32'hF);
        chk("wrap_pre_count", wb_count, 32'd15);
        chk("wrap_rd10", read_data1_w, 32'h1000);
        chk("wrap_rd23", read_data2, 32'h100D);
        drive(1, 1, 32'hBEEF0001, 32'h0, 24, 24, 0);
        @(posedge clk);
        #1;
        chk("wrap_count_w", {28'b0, wb_count_w}, 32'h0);
        chk("wrap_count", wb_count, 32'd16);
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 0, 24, 0);
        #2;
        chk("wrap_rd24", read_data1, 32'hBEEF0001);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
